// File: rtl/pacman_mover.sv
// Pac-Man movement stage: proposes the next tile, waits for the collision verdict, then commits, refuses or respawns.
// Optional macro PACMAN_TUNNEL_WRAP_EN makes steps off a map edge wrap to the opposite edge.
module pacman_mover #(
  parameter int TICK_CYCLES = 5000000,
  parameter int WAIT_CYCLES = 4,
  parameter int MAP_W       = 40,
  parameter int MAP_H       = 30,
  parameter int START_X     = 20,
  parameter int START_Y     = 22
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] dir_req,
  input  logic       dir_valid,
  input  logic [3:0] collision_type,
  output logic [5:0] next_pacman_x,
  output logic [4:0] next_pacman_y,
  output logic [5:0] pacman_x,
  output logic [4:0] pacman_y,
  output logic       move_done,
  output logic       caught
);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
  localparam logic signed [6:0] MW = 7'(MAP_W);
  localparam logic signed [6:0] MH = 7'(MAP_H);
  localparam logic [5:0] SX = 6'(START_X);
  localparam logic [4:0] SY = 5'(START_Y);
  localparam logic [3:0] C_NONE = 4'd0;
  localparam logic [3:0] C_WALL = 4'd1;

  typedef enum logic [1:0] {S_IDLE, S_PROPOSE, S_DECIDE} state_t;

  state_t          state_q;
  logic [TW-1:0]   tick_q;
  logic [WW-1:0]   wait_q;
  logic [3:0]      cap_q;
  logic            try_sel_q;
  logic [1:0]      try_dir_q, cur_dir_q, want_dir_q;
  logic            cur_valid_q, want_valid_q;
  logic [5:0]      x_q, nx_q;
  logic [4:0]      y_q, ny_q;
  logic            move_done_q, caught_q;

  logic            tick_wrap, is_ghost, launch_d, cand_ok_d;
  logic [1:0]      sel_dir_d;
  logic signed [6:0] sx_d, sy_d;

  assign tick_wrap = (tick_q == TICK_LAST);
  assign is_ghost  = (cap_q inside {4'd4, 4'd5, 4'd8, 4'd9});
  assign sel_dir_d = (state_q == S_IDLE && want_valid_q) ? want_dir_q : cur_dir_q;

  // A new attempt starts on an idle tick, or as the fallback after the buffered request hit a wall.
  assign launch_d = (state_q == S_IDLE && tick_wrap && (want_valid_q || cur_valid_q)) ||
                    (state_q == S_DECIDE && cap_q == C_WALL && !try_sel_q && cur_valid_q);

  always_comb begin
    sx_d      = {1'b0, x_q};
    sy_d      = {2'b00, y_q};
    cand_ok_d = 1'b1;
    case (sel_dir_d)
      2'b00:   sy_d = sy_d - 7'sd1;
      2'b01:   sy_d = sy_d + 7'sd1;
      2'b10:   sx_d = sx_d - 7'sd1;
      default: sx_d = sx_d + 7'sd1;
    endcase
`ifdef PACMAN_TUNNEL_WRAP_EN
    if (sx_d < 7'sd0)    sx_d = MW - 7'sd1;
    else if (sx_d >= MW) sx_d = 7'sd0;
    if (sy_d < 7'sd0)    sy_d = MH - 7'sd1;
    else if (sy_d >= MH) sy_d = 7'sd0;
`else
    if (sx_d < 7'sd0 || sx_d >= MW || sy_d < 7'sd0 || sy_d >= MH) cand_ok_d = 1'b0;
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      wait_q       <= '0;
      cap_q        <= C_NONE;
      try_sel_q    <= 1'b0;
      try_dir_q    <= 2'b00;
      cur_dir_q    <= 2'b00;
      cur_valid_q  <= 1'b0;
      want_dir_q   <= 2'b00;
      want_valid_q <= 1'b0;
      x_q          <= SX;
      y_q          <= SY;
      nx_q         <= SX;
      ny_q         <= SY;
      move_done_q  <= 1'b0;
      caught_q     <= 1'b0;
    end else begin
      move_done_q <= 1'b0;
      caught_q    <= 1'b0;
      tick_q      <= tick_wrap ? '0 : tick_q + TW'(1);
      case (state_q)
        S_PROPOSE: begin
          if (cap_q == C_NONE) cap_q <= collision_type;
          if (wait_q == WAIT_LAST) state_q <= S_DECIDE;
          wait_q <= wait_q + WW'(1);
        end
        S_DECIDE: begin
          state_q <= S_IDLE;
          if (is_ghost) begin
            x_q          <= SX;
            y_q          <= SY;
            nx_q         <= SX;
            ny_q         <= SY;
            cur_valid_q  <= 1'b0;
            want_valid_q <= 1'b0;
            caught_q     <= 1'b1;
          end else if (cap_q != C_WALL) begin
            x_q         <= nx_q;
            y_q         <= ny_q;
            move_done_q <= 1'b1;
            cur_dir_q   <= try_dir_q;
            cur_valid_q <= 1'b1;
            if (!try_sel_q) want_valid_q <= 1'b0;
          end else begin
            nx_q <= x_q;
            ny_q <= y_q;
          end
        end
        default: ;
      endcase
      // Off-map candidates skip the window and are judged as walls straight away.
      if (launch_d) begin
        try_sel_q <= (state_q == S_DECIDE) || !want_valid_q;
        try_dir_q <= sel_dir_d;
        wait_q    <= '0;
        if (cand_ok_d) begin
          state_q <= S_PROPOSE;
          cap_q   <= C_NONE;
          nx_q    <= sx_d[5:0];
          ny_q    <= sy_d[4:0];
        end else begin
          state_q <= S_DECIDE;
          cap_q   <= C_WALL;
          nx_q    <= x_q;
          ny_q    <= y_q;
        end
      end
      if (dir_valid) begin
        want_dir_q   <= dir_req;
        want_valid_q <= 1'b1;
      end
    end
  end

  assign next_pacman_x = nx_q;
  assign next_pacman_y = ny_q;
  assign pacman_x      = x_q;
  assign pacman_y      = y_q;
  assign move_done     = move_done_q;
  assign caught        = caught_q;
endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover: tick 16, window 4, start (20,22); collision detector is a tile/timing stub.
module tb_pacman_mover;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dir_req;
  logic       dir_valid;
  logic [3:0] collision_type;
  logic [5:0] next_x, pac_x;
  logic [4:0] next_y, pac_y;
  logic       move_done, caught;

`ifdef PACMAN_TUNNEL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  int errs = 0;
  int nchk = 0;
  int pcnt = 0;
  int win_cnt = 0;
  logic       ghost_mode;
  logic [5:0] e0x, e1x;
  logic [4:0] e0y, e1y;
  logic [3:0] e0c, e1c;
  logic       ok;

  pacman_mover #(.TICK_CYCLES(16), .WAIT_CYCLES(4), .MAP_W(40), .MAP_H(30),
                 .START_X(20), .START_Y(22)) dut (
    .CLOCK_50(clk), .reset(reset), .dir_req(dir_req), .dir_valid(dir_valid),
    .collision_type(collision_type), .next_pacman_x(next_x), .next_pacman_y(next_y),
    .pacman_x(pac_x), .pacman_y(pac_y), .move_done(move_done), .caught(caught));

  always #5 clk = ~clk;

  always @(posedge clk) if (!reset) pcnt <= pcnt + 1;

  // Counts cycles a proposal has been on the bus; ghost mode answers 0100 on the 2nd window cycle only.
  always @(negedge clk) win_cnt <= (next_x != pac_x || next_y != pac_y) ? win_cnt + 1 : 0;

  assign collision_type = ghost_mode ? ((win_cnt == 2) ? 4'd4 : 4'd0) :
                          (next_x == e0x && next_y == e0y) ? e0c :
                          (next_x == e1x && next_y == e1y) ? e1c : 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic at(input int n);
    while (pcnt < n) @(negedge clk);
  endtask

  task automatic strobe(input logic [1:0] d);
    dir_req = d; dir_valid = 1'b1;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; dir_valid = 1'b0; dir_req = 2'b00; ghost_mode = 1'b0;
    e0x = 6'd21; e0y = 5'd21; e0c = 4'd1;
    e1x = 6'd22; e1y = 5'd22; e1c = 4'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pac", {pac_x, pac_y}, {6'd20, 5'd22});
    chk("rst_next", {next_x, next_y}, {6'd20, 5'd22});
    chk("rst_pulses", {move_done, caught}, 2'b00);
    reset = 1'b0;

    // Right into an empty tile
    strobe(2'b11);
    at(15); chk("pre_wrap_next", next_x, 6'd20);
    for (int k = 16; k < 20; k++) begin
      at(k);
      chk("win_next_x", next_x, 6'd21);
      chk("win_pac_x", pac_x, 6'd20);
    end
    at(20); chk("decide_no_pulse", move_done, 1'b0);
    at(21); chk("commit_x", pac_x, 6'd21); chk("commit_pulse", move_done, 1'b1);
    at(22); chk("pulse_once", move_done, 1'b0);

    // Up blocked, fall back to right
    strobe(2'b00);
    at(32); chk("try_up", {next_x, next_y}, {6'd21, 5'd21});
    at(37); chk("retry_right", {next_x, next_y}, {6'd22, 5'd22});
    chk("retry_pac", {pac_x, pac_y}, {6'd21, 5'd22});
    at(42); chk("fallback_pac", {pac_x, pac_y}, {6'd22, 5'd22});
    chk("fallback_pulse", move_done, 1'b1);
    at(48); chk("up_retried", {next_x, next_y}, {6'd22, 5'd21});
    at(53); chk("up_commit", {pac_x, pac_y}, {6'd22, 5'd21});

    // Ghost catch
    at(55); ghost_mode = 1'b1;
    at(64); chk("ghost_prop", {next_x, next_y}, {6'd22, 5'd20});
    at(69); chk("caught_pulse", caught, 1'b1);
    chk("respawn_pac", {pac_x, pac_y}, {6'd20, 5'd22});
    chk("respawn_next", {next_x, next_y}, {6'd20, 5'd22});
    chk("respawn_no_move", move_done, 1'b0);
    at(70); chk("caught_once", caught, 1'b0); ghost_mode = 1'b0;
    at(81); chk("still_after_tick1", {next_x, next_y}, {6'd20, 5'd22});
    at(97); chk("still_after_tick2", {next_x, next_y}, {6'd20, 5'd22});
    at(98); chk("still_pac", {pac_x, pac_y}, {6'd20, 5'd22});

    // Pill-ghost code commits
    e0x = 6'd21; e0y = 5'd22; e0c = 4'd6;
    at(100); strobe(2'b11);
    at(116); chk("pill_decide_caught", caught, 1'b0);
    at(117); chk("pill_commit", {pac_x, pac_y}, {6'd21, 5'd22});
    chk("pill_pulse", move_done, 1'b1);
    chk("pill_no_caught", caught, 1'b0);
    at(118); chk("pill_no_caught2", caught, 1'b0);

    // Walk to (0,14) and step off the left edge
    e0x = 6'd63; e0y = 5'd31; e1x = 6'd63; e1y = 5'd31;
    strobe(2'b00);
    at(246); chk("walk_up", {pac_x, pac_y}, {6'd21, 5'd14});
    strobe(2'b10);
    at(582); chk("walk_left", {pac_x, pac_y}, {6'd0, 5'd14});
    at(592); chk("edge_next", next_x, WRAP ? 6'd39 : 6'd0);
    at(597); chk("edge_pac", pac_x, WRAP ? 6'd39 : 6'd0);
    chk("edge_pulse", move_done, WRAP ? 1'b1 : 1'b0);

    // Reset on the 2nd window cycle
    at(600); strobe(2'b11);
    at(608); chk("prop_before_rst", next_x, WRAP ? 6'd0 : 6'd1);
    at(609); reset = 1'b1;
    @(negedge clk);
    chk("midrst_pac", {pac_x, pac_y}, {6'd20, 5'd22});
    chk("midrst_next", {next_x, next_y}, {6'd20, 5'd22});
    chk("midrst_pulses", {move_done, caught}, 2'b00);
    reset = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (move_done || caught || next_x != 6'd20 || next_y != 5'd22) ok = 1'b0;
    end
    chk("post_rst_idle", ok, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
